// File: rtl/wb_trace_buffer_pkg.sv
// Shared widths and helpers for the write-back trace buffer.
// Register bus widths track the core's RegAddrBus/RegBus.
package wb_trace_buffer_pkg;

  localparam int   REG_ADDR_W = 5;
  localparam int   REG_W      = 32;
  // Reset is active-low here, unlike the core's RstEnable.
  localparam logic RST_ACTIVE = 1'b0;

  // A write to $0 has no architectural effect, so it is not an event.
  function automatic logic is_trace_event(input logic we,
                                          input logic [REG_ADDR_W-1:0] addr);
    return we && (addr != '0);
  endfunction

endpackage

// File: rtl/wb_trace_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output.
// Full/empty come from the level counter so pointers may wrap freely.
module wb_trace_buffer_sync_fifo
  import wb_trace_buffer_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && !clr && (!full || do_pop);

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        level <= level + 1'b1;
      end else if (do_pop && !do_push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures architectural register writes with a cycle stamp into a FIFO
// drained over valid/ready; drops on overflow are flagged and counted.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int CYC_W  = 32,
  parameter  int DROP_W = 8,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_waddr,
  input  logic [REG_W-1:0]      wb_wdata,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [REG_ADDR_W-1:0] trace_addr,
  output logic [REG_W-1:0]      trace_data,
  output logic [CYC_W-1:0]      trace_cycle,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_cnt,
  output logic [LVL_W-1:0]      level
);

  localparam int ENTRY_W = REG_ADDR_W + REG_W + CYC_W;

  logic [CYC_W-1:0]   cyc_cnt;
  logic [ENTRY_W-1:0] head;
  logic               trace_evt;
  logic               pop;
  logic               full;
  logic               empty;
  logic               drop;

  assign trace_evt   = is_trace_event(wb_we, wb_waddr);
  assign trace_valid = !empty;
  assign pop         = trace_valid && trace_ready;
  assign drop        = trace_evt && full && !pop && !clr;

  // Masking keeps the head outputs at zero while empty, hiding stale RAM.
  assign {trace_addr, trace_data, trace_cycle} = trace_valid ? head : '0;

  wb_trace_buffer_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (trace_evt),
    .pop   (pop),
    .wdata ({wb_waddr, wb_wdata, cyc_cnt}),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule
